// File: rtl/gru_bptt_sequencer_if.sv
// Bus between the GRU BPTT sequencer, the training controller and the gradient datapath.
// slave is the sequencer's view; master is the controller/datapath view.
interface gru_bptt_sequencer_if #(
  parameter int DATABIT = 16,
  parameter int STEPBIT = 8,
  parameter int ACCBIT  = 24
);
  logic                      start;
  logic [STEPBIT-1:0]        num_steps;
  logic                      step_req;
  logic [STEPBIT-1:0]        step_addr;
  logic                      op_valid;
  logic                      en;
  logic                      result_valid;
  logic signed [DATABIT-1:0] result_0;
  logic signed [DATABIT-1:0] result_1;
  logic signed [DATABIT-1:0] result_2;
  logic signed [DATABIT-1:0] result_3;
  logic signed [DATABIT-1:0] dh0_dw;
  logic signed [DATABIT-1:0] dh1_dw;
  logic signed [DATABIT-1:0] dh2_dw;
  logic signed [DATABIT-1:0] dh3_dw;
  logic signed [ACCBIT-1:0]  acc_0;
  logic signed [ACCBIT-1:0]  acc_1;
  logic signed [ACCBIT-1:0]  acc_2;
  logic signed [ACCBIT-1:0]  acc_3;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport slave (
    input  start, num_steps, op_valid, result_valid,
           result_0, result_1, result_2, result_3,
    output step_req, step_addr, en, dh0_dw, dh1_dw, dh2_dw, dh3_dw,
           acc_0, acc_1, acc_2, acc_3, busy, done, err
  );

  modport master (
    output start, num_steps, op_valid, result_valid,
           result_0, result_1, result_2, result_3,
    input  step_req, step_addr, en, dh0_dw, dh1_dw, dh2_dw, dh3_dw,
           acc_0, acc_1, acc_2, acc_3, busy, done, err
  );
endinterface

// File: rtl/gru_bptt_sequencer.sv
// Walks the GRU gradient datapath backward through time, feeding each step's
// results back as the next step's dh inputs and summing them into saturating accumulators.
module gru_bptt_sequencer #(
  parameter int DATABIT = 16,
  parameter int CELLNUM = 4,
  parameter int STEPBIT = 8,
  parameter int ACCBIT  = 24,
  parameter int TIMEOUT = 63
) (
  input logic                 clk,
  input logic                 rst_n,
  gru_bptt_sequencer_if.slave bus
);
  localparam int              TBIT = $clog2(TIMEOUT + 1);
  localparam logic [TBIT-1:0] TMAX = TBIT'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_UPDATE, S_FINISH
  } state_t;

  state_t                    state_q, state_d;
  logic [TBIT-1:0]           tcnt_q;
  logic [STEPBIT-1:0]        step_q;
  logic                      err_q;
  logic signed [DATABIT-1:0] dh_q    [CELLNUM];
  logic signed [DATABIT-1:0] res     [CELLNUM];
  logic signed [ACCBIT-1:0]  acc_q   [CELLNUM];
  logic signed [ACCBIT-1:0]  acc_sat [CELLNUM];
  logic signed [ACCBIT:0]    sum     [CELLNUM];

  logic accept, clr_err, set_err, capture, tcnt_clr, tcnt_inc, acc_upd, step_dec;
  logic tmo;

  assign tmo    = (tcnt_q == TMAX);
  assign res[0] = bus.result_0;
  assign res[1] = bus.result_1;
  assign res[2] = bus.result_2;
  assign res[3] = bus.result_3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    clr_err  = 1'b0;
    set_err  = 1'b0;
    capture  = 1'b0;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    acc_upd  = 1'b0;
    step_dec = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          clr_err = 1'b1;
          if (bus.num_steps != '0) begin
            accept  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      // Operand arrival is checked before the timeout so a late op_valid still wins.
      S_FETCH: begin
        if (bus.op_valid) begin
          tcnt_clr = 1'b1;
          state_d  = S_ISSUE;
        end else if (tmo) begin
          set_err = 1'b1;
          state_d = S_FINISH;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.result_valid) begin
          capture  = 1'b1;
          tcnt_clr = 1'b1;
          state_d  = S_UPDATE;
        end else if (tmo) begin
          set_err = 1'b1;
          state_d = S_FINISH;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      S_UPDATE: begin
        acc_upd = 1'b1;
        if (step_q == '0) begin
          state_d = S_FINISH;
        end else begin
          step_dec = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // One extra headroom bit exposes overflow; clamp when it disagrees with the sign bit.
  always_comb begin
    for (int unsigned i = 0; i < CELLNUM; i++) begin
      sum[i] = {acc_q[i][ACCBIT-1], acc_q[i]}
             + {{(ACCBIT + 1 - DATABIT){dh_q[i][DATABIT-1]}}, dh_q[i]};
      if (sum[i][ACCBIT] != sum[i][ACCBIT-1])
        acc_sat[i] = sum[i][ACCBIT] ? {1'b1, {(ACCBIT-1){1'b0}}} : {1'b0, {(ACCBIT-1){1'b1}}};
      else
        acc_sat[i] = sum[i][ACCBIT-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      step_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < CELLNUM; i++) begin
        dh_q[i]  <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      if (accept || tcnt_clr) tcnt_q <= '0;
      else if (tcnt_inc)      tcnt_q <= tcnt_q + 1'b1;

      if (accept)        step_q <= bus.num_steps - 1'b1;
      else if (step_dec) step_q <= step_q - 1'b1;

      if (clr_err)      err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;

      for (int unsigned i = 0; i < CELLNUM; i++) begin
        if (accept) begin
          dh_q[i]  <= '0;
          acc_q[i] <= '0;
        end else begin
          if (capture) dh_q[i]  <= res[i];
          if (acc_upd) acc_q[i] <= acc_sat[i];
        end
      end
    end
  end

  assign bus.step_req  = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.en        = (state_q == S_ISSUE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FINISH);
  assign bus.err       = err_q;
  assign bus.step_addr = step_q;
  assign bus.dh0_dw    = dh_q[0];
  assign bus.dh1_dw    = dh_q[1];
  assign bus.dh2_dw    = dh_q[2];
  assign bus.dh3_dw    = dh_q[3];
  assign bus.acc_0     = acc_q[0];
  assign bus.acc_1     = acc_q[1];
  assign bus.acc_2     = acc_q[2];
  assign bus.acc_3     = acc_q[3];
endmodule
